// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: widths, ALU opcodes, exception codes
// and the iterative multiply/divide FSM states.
package ex_stage_pkg;

   localparam int WORD_DATA_W = 32;
   localparam int WORD_ADDR_W = 30;
   localparam int ALU_OP_W    = 4;
   localparam int MEM_OP_W    = 2;
   localparam int CTRL_OP_W   = 2;
   localparam int REG_ADDR_W  = 5;
   localparam int ISA_EXP_W   = 3;
   localparam int MD_STATE_W  = 2;

   localparam logic ENABLE   = 1'b1;
   localparam logic DISABLE  = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam logic [MEM_OP_W-1:0]  MEM_OP_NOP  = '0;
   localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP = '0;

   localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_EXT_INT    = 3'd1;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_UNDEF_INSN = 3'd2;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_OVERFLOW   = 3'd3;

   // MUL/DIVU/REMU occupy previously unused opcode slots
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_OP_NOP  = 4'd0,
      ALU_OP_AND  = 4'd1,
      ALU_OP_OR   = 4'd2,
      ALU_OP_XOR  = 4'd3,
      ALU_OP_ADDS = 4'd4,
      ALU_OP_ADDU = 4'd5,
      ALU_OP_SUBS = 4'd6,
      ALU_OP_SUBU = 4'd7,
      ALU_OP_SHRL = 4'd8,
      ALU_OP_SHLL = 4'd9,
      ALU_OP_MUL  = 4'd10,
      ALU_OP_DIVU = 4'd11,
      ALU_OP_REMU = 4'd12
   } alu_op_e;

   typedef enum logic [MD_STATE_W-1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic is_md_op(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_OP_MUL) || (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply / divide: one shift-add or restoring-subtract
// step per cycle over a {hi,lo} register pair, 32 steps per operation.
module ex_muldiv
   import ex_stage_pkg::*;
#(
   parameter int DATA_W = WORD_DATA_W
)
(
   input  logic                clk,
   input  logic                reset_,
   input  logic                i_start,
   input  logic [ALU_OP_W-1:0] i_op,
   input  logic [DATA_W-1:0]   i_a,
   input  logic [DATA_W-1:0]   i_b,
   input  logic                i_stall,
   input  logic                i_flush,
   output logic                o_busy,
   output logic                o_done,
   output logic [DATA_W-1:0]   o_result
);

   localparam int CNT_W = $clog2(DATA_W);

   md_state_e           r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;
   logic [DATA_W-1:0]   r_b;
   logic [ALU_OP_W-1:0] r_op;

   logic [DATA_W:0]     w_add;
   logic [DATA_W:0]     w_sh;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W-1:0]   w_hi_nx;
   logic [DATA_W-1:0]   w_lo_nx;

   assign o_busy   = ((r_state == MD_IDLE) && i_start) || (r_state == MD_RUN);
   assign o_done   = (r_state == MD_DONE);
   assign o_result = (r_op == ALU_OP_REMU) ? r_hi : r_lo;

   // MUL shifts the product right through hi:lo; DIV shifts the quotient in at lo[0]
   always_comb begin
      w_add   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
      w_sh    = {r_hi, r_lo[DATA_W-1]};
      w_diff  = w_sh - {1'b0, r_b};
      w_hi_nx = r_hi;
      w_lo_nx = r_lo;
      if (r_op == ALU_OP_MUL) begin
         w_hi_nx = w_add[DATA_W:1];
         w_lo_nx = {w_add[0], r_lo[DATA_W-1:1]};
      end else begin
         w_hi_nx = w_diff[DATA_W] ? w_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
         w_lo_nx = {r_lo[DATA_W-2:0], ~w_diff[DATA_W]};
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (i_start) begin
                  r_state <= MD_RUN;
                  r_cnt   <= '0;
               end
            end
            MD_RUN: begin
               if (i_flush && !i_stall) begin
                  r_state <= MD_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= MD_DONE;
               end
            end
            MD_DONE: begin
               if (!i_stall) r_state <= MD_IDLE;
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == MD_IDLE) && i_start) begin
         r_hi <= '0;
         r_lo <= i_a;
         r_b  <= i_b;
         r_op <= i_op;
      end else if (r_state == MD_RUN) begin
         r_hi <= w_hi_nx;
         r_lo <= w_lo_nx;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, optional iterative MUL/DIVU/REMU unit,
// and the EX/MEM pipeline register.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DATA_W = WORD_DATA_W,
   parameter int MD_EN  = 1
)
(
   input  logic                   clk,
   input  logic                   reset_,
   input  logic [WORD_ADDR_W-1:0] IDPC,
   input  logic                   IDEn,
   input  logic [ALU_OP_W-1:0]    IDALUOp,
   input  logic [DATA_W-1:0]      IDALUIn0,
   input  logic [DATA_W-1:0]      IDALUIn1,
   input  logic                   IDBrFlag,
   input  logic [MEM_OP_W-1:0]    IDMemOp,
   input  logic [DATA_W-1:0]      IDMemWrData,
   input  logic [CTRL_OP_W-1:0]   IDCtrlOp,
   input  logic [REG_ADDR_W-1:0]  IDDstAddr,
   input  logic                   IDGPRWE_,
   input  logic [ISA_EXP_W-1:0]   IDExpCode,
   input  logic                   Stall,
   input  logic                   Flush,
   output logic [DATA_W-1:0]      FwdData,
   output logic                   MDBusy,
   output logic [WORD_ADDR_W-1:0] EXPC,
   output logic                   EXEn,
   output logic                   EXBrFlag,
   output logic [MEM_OP_W-1:0]    EXMemOp,
   output logic [DATA_W-1:0]      EXMemWrData,
   output logic [CTRL_OP_W-1:0]   EXCtrlOp,
   output logic [REG_ADDR_W-1:0]  EXDstAddr,
   output logic                   EXGPRWE_,
   output logic [ISA_EXP_W-1:0]   EXExpCode,
   output logic [DATA_W-1:0]      EXOut
);

   alu_op_e               w_op;
   logic [DATA_W-1:0]     w_alu;
   logic                  w_ovf;
   logic                  w_no_exp;
   logic                  w_md_op;
   logic                  w_md_start;
   logic                  w_md_busy;
   logic                  w_md_done;
   logic [DATA_W-1:0]     w_md_result;
   logic                  w_undef;
   logic                  w_local_exp;
   logic [ISA_EXP_W-1:0]  w_exp;

   assign w_op     = alu_op_e'(IDALUOp);
   assign w_no_exp = (IDExpCode == ISA_EXP_NO_EXP);

   always_comb begin
      w_alu = IDALUIn0;
      w_ovf = 1'b0;
      case (w_op)
         ALU_OP_AND:  w_alu = IDALUIn0 & IDALUIn1;
         ALU_OP_OR:   w_alu = IDALUIn0 | IDALUIn1;
         ALU_OP_XOR:  w_alu = IDALUIn0 ^ IDALUIn1;
         ALU_OP_ADDS: begin
            w_alu = IDALUIn0 + IDALUIn1;
            w_ovf = (IDALUIn0[DATA_W-1] == IDALUIn1[DATA_W-1]) &&
                    (w_alu[DATA_W-1] != IDALUIn0[DATA_W-1]);
         end
         ALU_OP_ADDU: w_alu = IDALUIn0 + IDALUIn1;
         ALU_OP_SUBS: begin
            w_alu = IDALUIn0 - IDALUIn1;
            w_ovf = (IDALUIn0[DATA_W-1] != IDALUIn1[DATA_W-1]) &&
                    (w_alu[DATA_W-1] != IDALUIn0[DATA_W-1]);
         end
         ALU_OP_SUBU: w_alu = IDALUIn0 - IDALUIn1;
         ALU_OP_SHRL: w_alu = IDALUIn0 >> IDALUIn1[4:0];
         ALU_OP_SHLL: w_alu = IDALUIn0 << IDALUIn1[4:0];
         ALU_OP_MUL, ALU_OP_DIVU, ALU_OP_REMU: w_alu = '0;
         default:     w_alu = IDALUIn0;
      endcase
   end

   assign w_md_op = IDEn && w_no_exp && is_md_op(IDALUOp);

   // A flush that takes effect this edge must not launch a new iterative op
   generate
      if (MD_EN != 0) begin : g_md
         assign w_md_start = w_md_op && !(Flush && !Stall);
         assign w_undef    = 1'b0;
         ex_muldiv #(.DATA_W(DATA_W)) u_muldiv (
            .clk      (clk),
            .reset_   (reset_),
            .i_start  (w_md_start),
            .i_op     (IDALUOp),
            .i_a      (IDALUIn0),
            .i_b      (IDALUIn1),
            .i_stall  (Stall),
            .i_flush  (Flush),
            .o_busy   (w_md_busy),
            .o_done   (w_md_done),
            .o_result (w_md_result)
         );
      end else begin : g_no_md
         assign w_md_start  = 1'b0;
         assign w_undef     = w_md_op;
         assign w_md_busy   = 1'b0;
         assign w_md_done   = 1'b0;
         assign w_md_result = '0;
      end
   endgenerate

   assign FwdData = w_md_done ? w_md_result : w_alu;
   assign MDBusy  = w_md_busy;

   // Upstream exception code always takes priority over locally raised ones
   assign w_local_exp = w_no_exp && IDEn && (w_ovf || w_undef);
   always_comb begin
      w_exp = IDExpCode;
      if (w_no_exp && IDEn && w_ovf)        w_exp = ISA_EXP_OVERFLOW;
      else if (w_no_exp && IDEn && w_undef) w_exp = ISA_EXP_UNDEF_INSN;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         EXPC        <= '0;
         EXEn        <= DISABLE;
         EXBrFlag    <= 1'b0;
         EXMemOp     <= MEM_OP_NOP;
         EXMemWrData <= '0;
         EXCtrlOp    <= CTRL_OP_NOP;
         EXDstAddr   <= '0;
         EXGPRWE_    <= DISABLE_;
         EXExpCode   <= ISA_EXP_NO_EXP;
         EXOut       <= '0;
      end else if (!Stall) begin
         if (Flush || w_md_busy) begin
            EXPC        <= '0;
            EXEn        <= DISABLE;
            EXBrFlag    <= 1'b0;
            EXMemOp     <= MEM_OP_NOP;
            EXMemWrData <= '0;
            EXCtrlOp    <= CTRL_OP_NOP;
            EXDstAddr   <= '0;
            EXGPRWE_    <= DISABLE_;
            EXExpCode   <= ISA_EXP_NO_EXP;
            EXOut       <= '0;
         end else begin
            EXPC        <= IDPC;
            EXEn        <= IDEn;
            EXBrFlag    <= IDBrFlag;
            EXMemOp     <= IDMemOp;
            EXMemWrData <= IDMemWrData;
            EXCtrlOp    <= IDCtrlOp;
            EXDstAddr   <= IDDstAddr;
            EXGPRWE_    <= w_local_exp ? DISABLE_ : IDGPRWE_;
            EXExpCode   <= w_exp;
            EXOut       <= FwdData;
         end
      end
   end

endmodule
